test_sequencer: RTL and testbench

TEST_SEQUENCER -- requirements
Module: test_sequencer

---
 rtl/test_sequencer.sv | 165 ++++++++++++++++
 tb/tb_test_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/test_sequencer.sv
// ----------------------------------------------------------------------------
// test_sequencer
//
// Steps an IC tester through four stimulus vectors. Each vector is held for
// SETTLE_CYCLES cycles, then the downstream pin checker's result is consumed
// in a single SAMPLE cycle. The four results are ANDed into a sweep verdict.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before sampling (2..255)
//
// Ports
//   clk       in   system clock, all state on the rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   level request to begin a sweep, only acted on in IDLE
//   number    in   [3:0] IC type selector, legal codes 0..6
//   pass_in   in   per-vector compare result from the pin checker
//   number_q  out  [3:0] IC type latched at start
//   seq       out  [1:0] current stimulus vector index 0..3
//                  ("sequence" is a reserved word in SystemVerilog)
//   sample    out  one-cycle strobe: pass_in is consumed this cycle
//   busy      out  high from sweep start until the DONE state is left
//   done      out  one-cycle pulse, sweep finished
//   verdict   out  1 = all four vectors passed; held until the next sweep ends
//   fail_vec  out  [1:0] index of first failing vector
//                  (only when FAIL_CAPTURE_EN is defined)
//
// Build option
//   FAIL_CAPTURE_EN  adds the fail_vec port and its capture logic.
// ----------------------------------------------------------------------------
module test_sequencer #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] number,
    input  logic       pass_in,
    output logic [3:0] number_q,
    output logic [1:0] seq,
    output logic       sample,
    output logic       busy,
    output logic       done,
    output logic       verdict
`ifdef FAIL_CAPTURE_EN
    ,
    output logic [1:0] fail_vec
`endif
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             acc;
    logic             number_ok;

    assign number_ok = (number <= 4'd6);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and strobe outputs
    always_comb begin
        state_next = state;
        sample     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = number_ok ? SETTLE : DONE;
                end
            end
            SETTLE: begin
                if (cnt == CNT_LAST) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                sample     = 1'b1;
                state_next = (seq == 2'd3) ? DONE : SETTLE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Sweep datapath: latched type, vector index, settle counter, verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number_q <= 4'd0;
            seq      <= 2'd0;
            cnt      <= '0;
            acc      <= 1'b1;
            busy     <= 1'b0;
            verdict  <= 1'b0;
`ifdef FAIL_CAPTURE_EN
            fail_vec <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        number_q <= number;
`ifdef FAIL_CAPTURE_EN
                        fail_vec <= 2'd0;
`endif
                        if (number_ok) begin
                            seq  <= 2'd0;
                            cnt  <= '0;
                            acc  <= 1'b1;
                            busy <= 1'b1;
                        end else begin
                            // Illegal type: no vectors are driven, sweep fails outright
                            verdict <= 1'b0;
                        end
                    end
                end
                SETTLE: begin
                    // Hold at the terminal count so the counter can never wrap
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    acc <= acc & pass_in;
`ifdef FAIL_CAPTURE_EN
                    // acc still high means no earlier vector has failed
                    if (acc && !pass_in) begin
                        fail_vec <= seq;
                    end
`endif
                    if (seq != 2'd3) begin
                        seq <= seq + 2'd1;
                        cnt <= '0;
                    end else begin
                        verdict <= acc & pass_in;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
// ----------------------------------------------------------------------------
// tb_test_sequencer
//
// Directed and randomized sweeps of test_sequencer (default SETTLE_CYCLES).
// Expected outputs come from cycle arithmetic: with cycle 1 being the cycle
// after the accepted start edge, vector k is sampled in cycle 17*(k+1), done
// is high in cycle 69 and the block is back in IDLE in cycle 70.
// ----------------------------------------------------------------------------
module tb_test_sequencer;

    localparam int S      = 16;
    localparam int P      = S + 1;
    localparam int DONE_C = 4 * P + 1;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] number;
    logic       pass_in;
    logic [3:0] number_q;
    logic [1:0] seq;
    logic       sample;
    logic       busy;
    logic       done;
    logic       verdict;
`ifdef FAIL_CAPTURE_EN
    logic [1:0] fail_vec;
`endif

    int   vectors     = 0;
    int   miscompares = 0;
    logic exp_verdict;
    int   exp_seq;

    test_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .number   (number),
        .pass_in  (pass_in),
        .number_q (number_q),
        .seq      (seq),
        .sample   (sample),
        .busy     (busy),
        .done     (done),
        .verdict  (verdict)
`ifdef FAIL_CAPTURE_EN
        ,
        .fail_vec (fail_vec)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int cyc, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_reset(input int cyc);
        chk("rst_number_q", cyc, 8'(number_q), 8'd0);
        chk("rst_seq",      cyc, 8'(seq),      8'd0);
        chk("rst_sample",   cyc, 8'(sample),   8'd0);
        chk("rst_busy",     cyc, 8'(busy),     8'd0);
        chk("rst_done",     cyc, 8'(done),     8'd0);
        chk("rst_verdict",  cyc, 8'(verdict),  8'd0);
`ifdef FAIL_CAPTURE_EN
        chk("rst_fail_vec", cyc, 8'(fail_vec), 8'd0);
`endif
    endtask

    // One sweep. Called shortly after a rising edge with the DUT in IDLE.
    // mode 0: pass_in always 1; mode 1: pass_in low only in the vector-2
    // sample cycle; mode 2: random pass_in with random start/number toggles.
    // hold keeps start high the whole time (back-to-back sweeps).
    task automatic sweep(input logic [3:0] num, input int mode, input bit hold);
        bit         valid;
        int         c_end;
        logic       acc;
        logic       new_v;
        logic [1:0] fexp;
        int         k;
        valid   = (num <= 4'd6);
        c_end   = valid ? DONE_C + 1 : 2;
        acc     = 1'b1;
        new_v   = 1'b0;
        fexp    = 2'd0;
        start   = 1'b1;
        number  = num;
        pass_in = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= c_end; c++) begin
            chk("number_q", c, 8'(number_q), 8'(num));
            if (valid) begin
                chk("sample",  c, 8'(sample), 8'((c <= 4 * P) && (c % P == 0)));
                chk("done",    c, 8'(done),   8'(c == DONE_C));
                chk("busy",    c, 8'(busy),   8'(c <= DONE_C));
                chk("seq",     c, 8'(seq),    8'((c <= 4 * P) ? (c - 1) / P : 3));
                chk("verdict", c, 8'(verdict), 8'((c >= DONE_C) ? new_v : exp_verdict));
`ifdef FAIL_CAPTURE_EN
                chk("fail_vec", c, 8'(fail_vec), 8'(fexp));
`endif
            end else begin
                chk("sample",  c, 8'(sample),  8'd0);
                chk("done",    c, 8'(done),    8'(c == 1));
                chk("busy",    c, 8'(busy),    8'd0);
                chk("seq",     c, 8'(seq),     8'(exp_seq));
                chk("verdict", c, 8'(verdict), 8'd0);
`ifdef FAIL_CAPTURE_EN
                chk("fail_vec", c, 8'(fail_vec), 8'd0);
`endif
            end
            if (c == c_end) break;
            // Inputs for cycle c
            if (hold)
                start = 1'b1;
            else if (mode == 2 && c < DONE_C && valid)
                start = 1'($urandom_range(0, 1));
            else
                start = 1'b0;
            if (hold || mode == 2)
                number = 4'($urandom_range(0, 15));
            case (mode)
                0:       pass_in = 1'b1;
                1:       pass_in = (c == 3 * P) ? 1'b0 : 1'b1;
                default: pass_in = ($urandom_range(0, 5) != 0);
            endcase
            // Reference model: consume pass_in in each vector's sample cycle
            if (valid && c <= 4 * P && c % P == 0) begin
                k = c / P - 1;
                if (acc && !pass_in) fexp = 2'(k);
                acc = acc & pass_in;
                if (k == 3) new_v = acc;
            end
            @(posedge clk);
            #1;
        end
        if (valid) begin
            exp_verdict = new_v;
            exp_seq     = 3;
        end else begin
            exp_verdict = 1'b0;
        end
    endtask

    initial begin
        clk     = 1'b0;
        rst_n   = 1'b1;
        start   = 1'b0;
        number  = 4'd0;
        pass_in = 1'b0;
        exp_verdict = 1'b0;
        exp_seq     = 0;

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #2 chk_reset(0);
        @(posedge clk);
        #1 chk_reset(0);
        #3 rst_n = 1'b1;

        // Illegal type straight after reset release
        sweep(4'd9, 0, 1'b0);
        // All vectors pass
        sweep(4'd2, 0, 1'b0);
        // Vector 2 fails
        sweep(4'd5, 1, 1'b0);
        // Back-to-back sweeps with start held and number toggling
        sweep(4'd0, 0, 1'b1);
        sweep(4'd0, 2, 1'b1);
        sweep(4'd0, 0, 1'b1);
        start = 1'b0;
        // Randomized sweeps, mixing legal and illegal types
        for (int i = 0; i < 10; i++) begin
            logic [3:0] n;
            if ($urandom_range(0, 3) == 0)
                n = 4'($urandom_range(7, 15));
            else
                n = 4'($urandom_range(0, 6));
            sweep(n, 2, 1'($urandom_range(0, 1)));
        end
        start = 1'b0;
        @(posedge clk);
        #1;

        // Reset during SETTLE of vector 1
        start   = 1'b1;
        number  = 4'd3;
        pass_in = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (24) begin
            @(posedge clk);
            #1;
        end
        chk("abort_seq",  25, 8'(seq),  8'd1);
        chk("abort_busy", 25, 8'(busy), 8'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset(25);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_done", 0, 8'(done), 8'd0);
            chk("abort_busy", 0, 8'(busy), 8'd0);
        end
        #3 rst_n = 1'b1;
        exp_verdict = 1'b0;
        exp_seq     = 0;
        // Clean sweep accepted on the first edge after release
        sweep(4'd4, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
